// File: rtl/mainfsm_pkg.sv
// Shared types and encodings for the multicycle control FSM.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BRANCH
  } state_t;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_RDDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  // Op instruction classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/mainfsm_outdec.sv
// Output decoder: state plus memory-ready gating to datapath strobes/selects.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       next_pc,
  output logic       reg_w,
  output logic       mem_w,
  output logic       branch,
  output logic       alu_op,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic       alu_src_b_unused_guard,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       done
);

  assign alu_src_b_unused_guard = 1'b0;

  // Per-state strobe/select decode; anything not named for a state stays 0.
  always_comb begin
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_WD;
    result_src = RES_ALUOUT;
    done       = 1'b0;
    case (state)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        ir_write   = mem_ready;
        next_pc    = mem_ready;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      MEMADR: begin
        alu_src_b  = SRCB_IMM;
      end
      MEMRD: begin
        adr_src    = 1'b1;
      end
      MEMWB: begin
        result_src = RES_RDDATA;
        reg_w      = 1'b1;
        done       = 1'b1;
      end
      MEMWR: begin
        adr_src    = 1'b1;
        mem_w      = 1'b1;
        done       = mem_ready;
      end
      EXECUTER: begin
        alu_op     = 1'b1;
      end
      EXECUTEI: begin
        alu_src_b  = SRCB_IMM;
        alu_op     = 1'b1;
      end
      ALUWB: begin
        reg_w      = 1'b1;
        done       = 1'b1;
      end
      BRANCH: begin
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        branch     = 1'b1;
        done       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle processor main control FSM.
// Optional retired-instruction counter: define MAINFSM_INSTRET_EN.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       instr_done
`ifdef MAINFSM_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  state_t state, state_next;
  logic   ready_gated;
  logic   dec_done;
  logic   unused_guard;
  logic   unused_funct;

  // Only the immediate and load/store bits of Funct steer this FSM.
  assign unused_funct = ^Funct[4:1];

  // Async reset already parks the state in FETCH; gating ready by reset
  // keeps the FETCH strobes low for as long as reset is held.
  assign ready_gated = mem_ready & reset;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // Next-state logic; Op/Funct are consulted only in DECODE and MEMADR.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:    if (mem_ready) state_next = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_next = MEMADR;
          OP_DP:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (mem_ready) state_next = MEMWB;
      MEMWB:    state_next = FETCH;
      MEMWR:    if (mem_ready) state_next = FETCH;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      ALUWB:    state_next = FETCH;
      BRANCH:   state_next = FETCH;
      default:  state_next = FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state                  (state),
    .mem_ready              (ready_gated),
    .ir_write               (IRWrite),
    .next_pc                (NextPC),
    .reg_w                  (RegW),
    .mem_w                  (MemW),
    .branch                 (Branch),
    .alu_op                 (ALUOp),
    .adr_src                (AdrSrc),
    .alu_src_a              (ALUSrcA),
    .alu_src_b_unused_guard (unused_guard),
    .alu_src_b              (ALUSrcB),
    .result_src             (ResultSrc),
    .done                   (dec_done)
  );

  // An illegal Op retires in DECODE, so completion is the one output that
  // also looks at Op; every strobe/select stays purely state-driven.
  assign instr_done = dec_done | ((state == DECODE) && (Op == OP_ILL));

`ifdef MAINFSM_INSTRET_EN
  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          instret <= '0;
    else if (instr_done) instret <= instret + INSTRET_W'(1);
  end
`endif

endmodule

// File: tb/tb_mainfsm.sv
// Directed testbench for mainfsm.
// Instret checks are active when MAINFSM_INSTRET_EN is defined.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc;
  logic       instr_done;
`ifdef MAINFSM_INSTRET_EN
  logic [31:0] instret;
`endif

  int checks;
  int errors;

  mainfsm #(.INSTRET_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .ALUOp      (ALUOp),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .instr_done (instr_done)
`ifdef MAINFSM_INSTRET_EN
    ,
    .instret    (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector: IRWrite NextPC RegW MemW Branch ALUOp AdrSrc ALUSrcA ALUSrcB ResultSrc instr_done
  localparam logic [12:0] V_RST    = 13'b0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [12:0] V_FRDY   = 13'b1_1_0_0_0_0_0_1_10_10_0;
  localparam logic [12:0] V_FWAIT  = 13'b0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [12:0] V_DEC    = 13'b0_0_0_0_0_0_0_1_10_10_0;
  localparam logic [12:0] V_DECILL = 13'b0_0_0_0_0_0_0_1_10_10_1;
  localparam logic [12:0] V_MADR   = 13'b0_0_0_0_0_0_0_0_01_00_0;
  localparam logic [12:0] V_MRD    = 13'b0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [12:0] V_MWB    = 13'b0_0_1_0_0_0_0_0_00_01_1;
  localparam logic [12:0] V_MWRW   = 13'b0_0_0_1_0_0_1_0_00_00_0;
  localparam logic [12:0] V_MWRD   = 13'b0_0_0_1_0_0_1_0_00_00_1;
  localparam logic [12:0] V_EXR    = 13'b0_0_0_0_0_1_0_0_00_00_0;
  localparam logic [12:0] V_EXI    = 13'b0_0_0_0_0_1_0_0_01_00_0;
  localparam logic [12:0] V_AWB    = 13'b0_0_1_0_0_0_0_0_00_00_1;
  localparam logic [12:0] V_BR     = 13'b0_0_0_0_1_0_0_0_01_10_1;

  function automatic logic [12:0] outs();
    return {IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA,
            ALUSrcB, ResultSrc, instr_done};
  endfunction

  task automatic check_vec(input string tag, input logic [12:0] exp);
    logic [12:0] got;
    got = outs();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic check_instret(input string tag, input logic [31:0] exp);
`ifdef MAINFSM_INSTRET_EN
    checks++;
    assert (instret === exp) else begin
      errors++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, exp);
    end
`endif
  endtask

  // One clock cycle: apply inputs, sample at the falling edge, advance.
  task automatic cyc(input logic mr, input logic [1:0] op, input logic [5:0] fn,
                     input logic [12:0] exp, input string tag);
    mem_ready = mr;
    Op        = op;
    Funct     = fn;
    @(negedge clk);
    check_vec(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    mem_ready = 1'b1;
    Op        = 2'b00;
    Funct     = 6'b000000;
    #3;
    check_vec("reset_state", V_RST);
    check_instret("reset_instret", 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ADD register
    cyc(1'b1, 2'b00, 6'b001000, V_FRDY, "add_fetch");
    cyc(1'b1, 2'b00, 6'b001000, V_DEC,  "add_decode");
    check_instret("add_instret_before", 32'd0);
    cyc(1'b1, 2'b00, 6'b001000, V_EXR,  "add_exec");
    cyc(1'b1, 2'b00, 6'b001000, V_AWB,  "add_aluwb");
    check_instret("add_instret_after", 32'd1);

    // LDR with two memory wait cycles in MEMRD
    cyc(1'b1, 2'b01, 6'b011001, V_FRDY, "ldr_fetch");
    cyc(1'b1, 2'b01, 6'b011001, V_DEC,  "ldr_decode");
    cyc(1'b1, 2'b01, 6'b011001, V_MADR, "ldr_memadr");
    cyc(1'b0, 2'b01, 6'b011001, V_MRD,  "ldr_memrd_w1");
    cyc(1'b0, 2'b01, 6'b011001, V_MRD,  "ldr_memrd_w2");
    cyc(1'b1, 2'b01, 6'b011001, V_MRD,  "ldr_memrd_rdy");
    cyc(1'b1, 2'b01, 6'b011001, V_MWB,  "ldr_memwb");
    check_instret("ldr_instret", 32'd2);

    // STR with three wait cycles in MEMWR; also a stalled fetch first
    cyc(1'b0, 2'b01, 6'b011000, V_FWAIT, "str_fetch_wait");
    cyc(1'b1, 2'b01, 6'b011000, V_FRDY,  "str_fetch");
    cyc(1'b1, 2'b01, 6'b011000, V_DEC,   "str_decode");
    cyc(1'b1, 2'b01, 6'b011000, V_MADR,  "str_memadr");
    cyc(1'b0, 2'b01, 6'b011000, V_MWRW,  "str_memwr_w1");
    cyc(1'b0, 2'b01, 6'b011000, V_MWRW,  "str_memwr_w2");
    cyc(1'b0, 2'b01, 6'b011000, V_MWRW,  "str_memwr_w3");
    cyc(1'b1, 2'b01, 6'b011000, V_MWRD,  "str_memwr_rdy");
    check_instret("str_instret", 32'd3);

    // Branch
    cyc(1'b1, 2'b10, 6'b000000, V_FRDY, "b_fetch");
    cyc(1'b1, 2'b10, 6'b000000, V_DEC,  "b_decode");
    cyc(1'b1, 2'b10, 6'b000000, V_BR,   "b_branch");
    check_instret("b_instret", 32'd4);

    // Illegal Op retires in DECODE
    cyc(1'b1, 2'b11, 6'b111111, V_FRDY,   "ill_fetch");
    cyc(1'b1, 2'b11, 6'b111111, V_DECILL, "ill_decode");
    check_instret("ill_instret", 32'd5);

    // Immediate data-processing; Op changes in EXECUTEI are ignored
    cyc(1'b1, 2'b00, 6'b100000, V_FRDY, "addi_fetch");
    cyc(1'b1, 2'b00, 6'b100000, V_DEC,  "addi_decode");
    cyc(1'b1, 2'b11, 6'b000001, V_EXI,  "addi_exec");
    cyc(1'b1, 2'b10, 6'b000001, V_AWB,  "addi_aluwb");
    check_instret("addi_instret", 32'd6);

    // Reset in the middle of a MEMWR stall
    cyc(1'b1, 2'b01, 6'b011000, V_FRDY, "rst_fetch");
    cyc(1'b1, 2'b01, 6'b011000, V_DEC,  "rst_decode");
    cyc(1'b1, 2'b01, 6'b011000, V_MADR, "rst_memadr");
    mem_ready = 1'b0;
    @(negedge clk);
    check_vec("rst_memwr_stall", V_MWRW);
    #2;
    reset = 1'b0;
    #1;
    check_vec("rst_async_memw_drop", V_RST);
    check_instret("rst_async_instret", 32'd0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check_vec("rst_held_ready", V_RST);
    reset = 1'b1;

    // First instruction after reset
    cyc(1'b1, 2'b10, 6'b000000, V_FRDY, "post_fetch");
    cyc(1'b1, 2'b10, 6'b000000, V_DEC,  "post_decode");
    cyc(1'b1, 2'b10, 6'b000000, V_BR,   "post_branch");
    cyc(1'b0, 2'b10, 6'b000000, V_FWAIT, "post_fetch_again");
    check_instret("post_instret", 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
